// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl -- execute-stage hazard controller for the pipelined RV core.
//
// Purpose:
//   - EX operand forwarding selects (forwardA / forwardB) from MEM and WB.
//   - Load-use bubble insertion.
//   - Wrong-path flush on a taken branch.
//   - Holds IF/ID/EX while a multi-cycle (mul/div) op occupies EX.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   id_rs1, id_rs2                  sources of the instruction in ID
//   ex_rs1, ex_rs2, ex_rd           sources/destination of the instruction in EX
//   ex_mem_read, ex_mc_start        EX is a load / EX starts a multi-cycle op
//   mem_rd, mem_reg_write           MEM destination and write enable
//   wb_rd, wb_reg_write             WB destination and write enable
//   branch_taken                    branch resolved taken in EX
//   forwardA, forwardB              00 regfile, 10 MEM, 01 WB
//   stall_if, stall_id, stall_ex    hold PC / IF-ID / ID-EX
//   flush_id, flush_ex              zero control bits of IF-ID / ID-EX
//   ex_busy, mc_done                multi-cycle op active / final-cycle pulse
//   stall_cycles, flush_events      perf counters (only with HAZ_PERF_CNT_EN)
//
// Build option: define HAZ_PERF_CNT_EN to add the stall/flush event counters.
module ex_hazard_ctrl #(
  parameter int MC_LAT = 4,
  parameter int RA_W   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] ex_rs1,
  input  logic [RA_W-1:0] ex_rs2,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_mem_read,
  input  logic            ex_mc_start,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_reg_write,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_reg_write,
  input  logic            branch_taken,
  output logic [1:0]      forwardA,
  output logic [1:0]      forwardB,
  output logic            stall_if,
  output logic            stall_id,
  output logic            stall_ex,
  output logic            flush_id,
  output logic            flush_ex,
  output logic            ex_busy,
`ifdef HAZ_PERF_CNT_EN
  output logic            mc_done,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     flush_events
`else
  output logic            mc_done
`endif
);

  localparam int CW = $clog2(MC_LAT);

  typedef enum logic {RUN, MC_BUSY} state_t;

  state_t          state;
  logic [CW-1:0]   mc_cnt;
  logic            load_use;

  // MEM has the newer value, so it wins over WB on a double match.
  function automatic logic [1:0] fwd_sel(
    input logic [RA_W-1:0] rs,
    input logic [RA_W-1:0] m_rd, input logic m_we,
    input logic [RA_W-1:0] w_rd, input logic w_we);
    if (m_we && m_rd != '0 && m_rd == rs)      return 2'b10;
    else if (w_we && w_rd != '0 && w_rd == rs) return 2'b01;
    else                                       return 2'b00;
  endfunction

  assign load_use = ex_mem_read && ex_rd != '0 &&
                    (ex_rd == id_rs1 || ex_rd == id_rs2);

  // Outputs are held low while reset is asserted so nothing (including a
  // stray mc_done) escapes during the reset cycle.
  always_comb begin
    stall_if = 1'b0;
    stall_id = 1'b0;
    stall_ex = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    ex_busy  = 1'b0;
    mc_done  = 1'b0;
    forwardA = 2'b00;
    forwardB = 2'b00;
    if (rst_n) begin
      if (state == RUN) begin
        if (branch_taken) begin
          flush_id = 1'b1;
          flush_ex = 1'b1;
        end else if (ex_mc_start) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          stall_ex = 1'b1;
          ex_busy  = 1'b1;
        end else if (load_use) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
        end
      end else begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        stall_ex = 1'b1;
        ex_busy  = 1'b1;
        mc_done  = (mc_cnt == '0);
      end
      // The multi-cycle unit captured its operands at start; bypass is moot.
      if (!ex_busy) begin
        forwardA = fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
        forwardB = fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
      end
    end
  end

  // First EX cycle is spent in RUN, so MC_BUSY runs MC_LAT-1 cycles:
  // counter loads MC_LAT-2 and the cycle where it reads 0 is the last.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= RUN;
      mc_cnt <= '0;
    end else if (state == RUN) begin
      if (!branch_taken && ex_mc_start) begin
        state  <= MC_BUSY;
        mc_cnt <= CW'(MC_LAT - 2);
      end
    end else begin
      if (mc_cnt == '0) state  <= RUN;
      else              mc_cnt <= mc_cnt - 1'b1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_if) stall_cycles <= stall_cycles + 32'd1;
      if (flush_id) flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
Pipeline hazard controller that sequences the execute stage of the pipelined RV core.
- Generates the forwardA/forwardB operand-mux selects consumed by the Execute stage.
- Inserts load-use bubbles.
- Flushes wrong-path instructions on a taken branch.
- Holds IF/ID/EX while a multi-cycle ALU operation (mul/div) occupies EX.

Parameters:
- MC_LAT, 4, cycles a multi-cycle op occupies EX (legal range 2..16)
- RA_W, 5, register-address width

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous active-low reset
- id_rs1, id_rs2  in  RA_W  source registers of the instruction in ID
- ex_rs1, ex_rs2  in  RA_W  source registers of the instruction in EX
- ex_rd  in  RA_W  destination register of the instruction in EX
- ex_mem_read  in  1  instruction in EX is a load
- ex_mc_start  in  1  instruction in EX is a multi-cycle op (valid in first EX cycle)
- mem_rd  in  RA_W  destination register in MEM
- mem_reg_write  in  1  MEM writes rd
- wb_rd  in  RA_W  destination register in WB
- wb_reg_write  in  1  WB writes rd
- branch_taken  in  1  branch resolved taken in EX
- forwardA, forwardB  out  2  operand select: 00 = regfile, 10 = MEM, 01 = WB
- stall_if, stall_id, stall_ex  out  1  hold the PC / IF-ID / ID-EX registers
- flush_id, flush_ex  out  1  zero the control bits of IF-ID / ID-EX
- ex_busy  out  1  multi-cycle op in progress
- mc_done  out  1  one-cycle pulse on the final multi-cycle cycle

Behaviour:
Clocking and reset
- Single clock; reset is synchronous and active-low (rst_n sampled on the clk rising edge).
- On reset: state = RUN, mc_cnt = 0, all stall/flush/busy/done outputs = 0, forwardA = forwardB = 00.

Forwarding (combinational, evaluated for ex_rs1 → forwardA and ex_rs2 → forwardB)
- 10 if mem_reg_write && mem_rd != 0 && mem_rd == rs.
- Else 01 if wb_reg_write && wb_rd != 0 && wb_rd == rs.
- Else 00. MEM beats WB on a double match.
- Forced to 00 while ex_busy = 1, because the multi-cycle unit latched its operands at start.

FSM states: RUN, MC_BUSY. Outputs are combinational from state and inputs.

RUN, priority 1 – branch_taken = 1:
- flush_id = flush_ex = 1 in the same cycle.
- ex_mc_start and the load-use check are ignored.
- Stay in RUN.

RUN, priority 2 – ex_mc_start = 1:
- stall_if = stall_id = stall_ex = 1, ex_busy = 1.
- mc_cnt ← MC_LAT−2; next state MC_BUSY.

RUN, priority 3 – load-use (ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2)):
- stall_if = stall_id = 1, flush_ex = 1 for exactly one cycle (bubble).
- Stay in RUN; the hazard clears naturally once the load advances.

MC_BUSY
- stall_if = stall_id = stall_ex = ex_busy = 1.
- mc_cnt decrements each cycle.
- When mc_cnt == 0: mc_done = 1 and next state RUN. In this cycle the stalls and ex_busy are still 1.
- branch_taken, ex_mc_start and the load-use check are ignored in MC_BUSY.

Occupancy and counter rules
- Total EX occupancy is exactly MC_LAT cycles: 1 in RUN plus MC_LAT−1 in MC_BUSY.
- mc_cnt is $clog2(MC_LAT) bits wide, counts down only, never wraps.

Back-to-back and reset
- A multi-cycle op immediately following another is accepted only from RUN. The cycle after mc_done is RUN, so back-to-back ops have no gap.
- rst_n low mid MC_BUSY: state RUN and mc_cnt 0 on the next edge; mc_done is not pulsed.

Optional Feature:
Macro HAZ_PERF_CNT_EN.
- Defined: adds output ports stall_cycles[31:0] and flush_events[31:0].
  - stall_cycles increments every cycle stall_if = 1.
  - flush_events increments every cycle flush_id = 1.
  - Both wrap at 2^32 and clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Forwarding: ex_rs1 = 5, mem_rd = 5, mem_reg_write = 1, wb_rd = 5, wb_reg_write = 1 → forwardA = 10. Then set mem_reg_write = 0 → forwardA = 01. With ex_rs2 = 0 and mem_rd = 0 → forwardB = 00.
- Load-use: ex_mem_read = 1, ex_rd = 7, id_rs2 = 7 → one cycle of stall_if = stall_id = flush_ex = 1. Next cycle, with ex_mem_read = 0, all are 0.
- Branch: branch_taken = 1 while a load-use condition is also true → flush_id = flush_ex = 1, stall_if = 0.
- Multi-cycle, MC_LAT = 4: ex_mc_start pulse at cycle t → stall_ex = 1 and ex_busy = 1 for cycles t..t+3; mc_done = 1 only at t+3; forwardA = 00 during t..t+3 despite a MEM match. branch_taken at t+1 → no flush.
- Reset mid-op: rst_n = 0 at t+1 of a multi-cycle op → at t+2 ex_busy = 0, stalls = 0, and mc_done is never pulsed.
- HAZ_PERF_CNT_EN: one load-use bubble plus one MC_LAT = 4 op plus one branch → stall_cycles = 5, flush_events = 1.
